brc_serial: RTL and testbench
=============================

BRC_SERIAL -- requirements
Module: brc_serial

Interface
REQ-001 Parameter XLEN, default 32: operand width in bits.
REQ-002 Parameter CHUNK, default 8: bits compared per cycle; XLEN SHALL be an integer multiple of CHUNK, and NCHUNK = XLEN/CHUNK.
REQ-003 i_clk  input  1: single clock, rising-edge active.
REQ-004 i_rst_n  input  1: reset, asynchronous and active-low.
REQ-005 i_valid  input  1: request valid.
REQ-006 o_ready  output  1: block can accept a request.
REQ-007 i_rs1_data  input  XLEN: operand A.
REQ-008 i_rs2_data  input  XLEN: operand B.
REQ-009 i_br_type  input  3: branch type. 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6-7 never taken.
REQ-010 i_flush  input  1: abort any request in flight.
REQ-011 o_valid  output  1: result valid.
REQ-012 i_ready  input  1: consumer accepts the result.
REQ-013 o_pc_sel  output  1: branch taken.
REQ-014 o_equal, o_less  output  1 each: final comparison flags (o_less is signed for types 2/3 and unsigned otherwise).

Function
REQ-015 FSM states: IDLE, BUSY, DONE.
REQ-016 o_ready SHALL be 1 only in IDLE.
REQ-017 Accept: i_valid & o_ready at a clock edge latches both operands and i_br_type, clears the chunk counter, sets borrow=0 and zero=1, and enters BUSY.
REQ-018 Per BUSY cycle, at chunk k (LSB first): {borrow, diff} = A[k] - B[k] - borrow; zero &= (diff == 0); k++.
REQ-019 After chunk NCHUNK-1, the FSM SHALL enter DONE; o_valid rises exactly NCHUNK cycles after the accepting edge.
REQ-020 o_equal = zero.
REQ-021 Unsigned less = final borrow.
REQ-022 Signed less = A[XLEN-1] when the operand MSBs differ, else the final borrow.
REQ-023 o_pc_sel: BEQ eq; BNE !eq; BLT/BLTU less; BGE/BGEU !less; types 6-7 give 0.
REQ-024 In DONE, o_valid=1 and the outputs are held stable until i_ready=1; o_valid & i_ready then returns the FSM to IDLE.
REQ-025 No back-to-back overlap: a new request cannot be accepted in the cycle the result is consumed.
REQ-026 i_flush=1 in BUSY or DONE forces IDLE at the next edge, with o_valid=0 and no result delivered.
REQ-027 i_flush has priority over accept and consume.
REQ-028 i_flush in IDLE blocks acceptance that cycle.
REQ-029 Outputs o_pc_sel, o_equal and o_less SHALL be 0 whenever o_valid=0.
REQ-030 Changes on the operand inputs after acceptance SHALL not affect the result.

Reset
REQ-031 i_rst_n=0 forces IDLE, clears the counter, borrow, zero and latched operands, and sets o_valid=0, o_pc_sel=0, o_equal=0, o_less=0 and o_ready=1, asynchronously.
REQ-032 Reset asserted mid-operation discards the request; after release, the block is in IDLE and can accept on the first edge.

Configuration
REQ-033 Macro BRC_SERIAL_PRED_EN: when defined, input i_pred_taken (1) is latched on accept, and output o_mispred (1) = o_valid & (o_pc_sel != latched prediction), 0 on reset and when o_valid=0.
REQ-034 When BRC_SERIAL_PRED_EN is undefined, neither port exists and behaviour is otherwise identical.

Verification
REQ-035 XLEN=32, CHUNK=8; BEQ with A=B=0x1234_5678 -> o_valid exactly 4 cycles after accept, o_equal=1, o_pc_sel=1.
REQ-036 BLT A=0xFFFF_FFFF (-1), B=0x0000_0001 -> o_less=1, o_pc_sel=1; the same operands with BLTU -> o_less=0, o_pc_sel=0.
REQ-037 BGEU A=0x0000_0100, B=0x0000_00FF (borrow across chunk boundary) -> o_less=0, o_equal=0, o_pc_sel=1.
REQ-038 BNE result held with i_ready=0 for 5 cycles -> o_valid and o_pc_sel stable and o_ready=0 throughout; i_ready=1 -> IDLE next cycle.
REQ-039 i_flush asserted 2 cycles into BUSY -> IDLE next edge, no o_valid pulse; i_rst_n low for 1 cycle mid-BUSY -> all outputs 0 and o_ready=1 immediately.
REQ-040 With BRC_SERIAL_PRED_EN defined, BGE A=5, B=7 and i_pred_taken=1 -> o_pc_sel=0, o_mispred=1 while o_valid=1.

Source files
------------

// File: rtl/brc_serial.sv
// brc_serial -- serial branch comparator.
//
// Compares two XLEN-bit operands CHUNK bits per cycle, LSB chunk first, with
// a rippled borrow. After XLEN/CHUNK cycles it presents the equal/less flags
// and the branch-taken decision. The result is held until the consumer takes
// it, or until a flush discards it.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_valid / o_ready      request handshake (o_ready only in IDLE)
//   i_rs1_data, i_rs2_data operands A and B
//   i_br_type              0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6-7 never
//   i_flush                abort any request in flight; blocks accept in IDLE
//   o_valid / i_ready      result handshake
//   o_pc_sel               branch taken
//   o_equal, o_less        final flags (o_less signed for BLT/BGE)
//
// Optional feature, enabled by defining BRC_SERIAL_PRED_EN:
//   i_pred_taken           prediction, latched on accept
//   o_mispred              o_valid & (o_pc_sel != latched prediction)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a request, o_ready=1
// BUSY  | comparing one chunk per cycle
// DONE  | result presented on o_valid, held until i_ready or flush

module brc_serial #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [2:0]      i_br_type,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_pc_sel,
  output logic            o_equal,
  output logic            o_less
`ifdef BRC_SERIAL_PRED_EN
  ,
  input  logic            i_pred_taken,
  output logic            o_mispred
`endif
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd2;
  localparam logic [2:0] BR_BGE  = 3'd3;
  localparam logic [2:0] BR_BLTU = 3'd4;
  localparam logic [2:0] BR_BGEU = 3'd5;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  // Operands are shifted right one chunk per cycle so the active chunk is
  // always the low CHUNK bits; the MSBs are kept aside for the signed compare.
  logic [XLEN-1:0] a_sh;
  logic [XLEN-1:0] b_sh;
  logic            a_msb;
  logic            b_msb;
  logic [2:0]      br_type_q;
  logic            borrow;
  logic            zero;

  logic [CHUNK:0]  sub;
  logic            signed_cmp;
  logic            less_raw;
  logic            pc_raw;

  always_comb begin
    sub = {1'b0, a_sh[CHUNK-1:0]} - {1'b0, b_sh[CHUNK-1:0]}
          - {{CHUNK{1'b0}}, borrow};
  end

`ifdef BRC_SERIAL_PRED_EN
  logic pred_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pred_q <= 1'b0;
    end else if (state == S_IDLE && i_valid && !i_flush) begin
      pred_q <= i_pred_taken;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      br_type_q <= 3'd0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid && !i_flush) begin
            a_sh      <= i_rs1_data;
            b_sh      <= i_rs2_data;
            a_msb     <= i_rs1_data[XLEN-1];
            b_msb     <= i_rs2_data[XLEN-1];
            br_type_q <= i_br_type;
            cnt       <= '0;
            borrow    <= 1'b0;
            zero      <= 1'b1;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (i_flush) begin
            state <= S_IDLE;
          end else begin
            a_sh   <= a_sh >> CHUNK;
            b_sh   <= b_sh >> CHUNK;
            borrow <= sub[CHUNK];
            zero   <= zero & (sub[CHUNK-1:0] == '0);
            cnt    <= cnt + CW'(1);
            if (cnt == LAST_CHUNK) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Flush and consume both land in IDLE; flush needs no separate path.
          if (i_flush || i_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    signed_cmp = (br_type_q == BR_BLT) || (br_type_q == BR_BGE);
    less_raw   = (signed_cmp && (a_msb != b_msb)) ? a_msb : borrow;
    case (br_type_q)
      BR_BEQ:  pc_raw = zero;
      BR_BNE:  pc_raw = !zero;
      BR_BLT,
      BR_BLTU: pc_raw = less_raw;
      BR_BGE,
      BR_BGEU: pc_raw = !less_raw;
      default: pc_raw = 1'b0;
    endcase
  end

  assign o_ready  = (state == S_IDLE);
  assign o_valid  = (state == S_DONE);
  assign o_pc_sel = o_valid & pc_raw;
  assign o_equal  = o_valid & zero;
  assign o_less   = o_valid & less_raw;

`ifdef BRC_SERIAL_PRED_EN
  assign o_mispred = o_valid & (pc_raw != pred_q);
`endif

endmodule

// File: tb/tb_brc_serial.sv
module tb_brc_serial;

  localparam int XLEN   = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = XLEN / CHUNK;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_valid;
  logic            o_ready;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic [2:0]      i_br_type;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic            o_pc_sel;
  logic            o_equal;
  logic            o_less;
`ifdef BRC_SERIAL_PRED_EN
  logic            i_pred_taken;
  logic            o_mispred;
`endif

  brc_serial #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_br_type  (i_br_type),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_pc_sel   (o_pc_sel),
    .o_equal    (o_equal),
    .o_less     (o_less)
`ifdef BRC_SERIAL_PRED_EN
    ,
    .i_pred_taken (i_pred_taken),
    .o_mispred    (o_mispred)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic pc;
    logic eq;
    logic lt;
    logic mis;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic prev_v = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: compares each newly presented result against the scoreboard.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n) begin
      if (o_valid && !prev_v) begin
        if (q.size() == 0) begin
          fail_now("unexpected_valid");
        end else begin
          e = q.pop_front();
          chk("pc_sel", {31'd0, o_pc_sel}, {31'd0, e.pc});
          chk("equal",  {31'd0, o_equal},  {31'd0, e.eq});
          chk("less",   {31'd0, o_less},   {31'd0, e.lt});
          chk("latency", cyc - acc_cyc, NCHUNK);
`ifdef BRC_SERIAL_PRED_EN
          chk("mispred", {31'd0, o_mispred}, {31'd0, e.mis});
`endif
        end
      end
      if (!o_valid) begin
        chk("gated_flags", {29'd0, o_pc_sel, o_equal, o_less}, 32'd0);
      end
    end
    prev_v = o_valid;
  end

  task automatic wait_ready();
    int k = 0;
    while (!o_ready && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    if (!o_ready) fail_now("ready_timeout");
  endtask

  // Issue one request, hold the result for 'hold' cycles, then consume it.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [2:0] t,
                     input logic pred, input logic epc, input logic eeq,
                     input logic elt, input logic emis, input int hold);
    exp_t e;
    int   k;
    wait_ready();
    i_rs1_data = a;
    i_rs2_data = b;
    i_br_type  = t;
    i_valid    = 1'b1;
`ifdef BRC_SERIAL_PRED_EN
    i_pred_taken = pred;
`else
    if (pred) k = 0;
`endif
    @(posedge i_clk);
    #1;
    acc_cyc = cyc;
    e.pc = epc; e.eq = eeq; e.lt = elt; e.mis = emis;
    q.push_back(e);
    i_valid    = 1'b0;
    i_rs1_data = ~a;
    i_rs2_data = a ^ 32'h5a5a_a5a5;
    i_br_type  = 3'd7 - t;
`ifdef BRC_SERIAL_PRED_EN
    i_pred_taken = ~pred;
`endif
    chk("accepted_busy", {31'd0, o_ready}, 32'd0);
    k = 0;
    @(negedge i_clk);
    while (!o_valid && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    if (!o_valid) begin
      fail_now("valid_timeout");
      return;
    end
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", {31'd0, o_valid},  32'd1);
      chk("hold_pc",    {31'd0, o_pc_sel}, {31'd0, epc});
      chk("hold_ready", {31'd0, o_ready},  32'd0);
      @(negedge i_clk);
    end
    // A request offered during the consume cycle must not be taken.
    i_ready = 1'b1;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    i_valid = 1'b0;
    chk("consume_valid", {31'd0, o_valid}, 32'd0);
    chk("consume_ready", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic start_only(input logic [31:0] a, input logic [31:0] b, input logic [2:0] t);
    wait_ready();
    i_rs1_data = a;
    i_rs2_data = b;
    i_br_type  = t;
    i_valid    = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst_n    = 1'b0;
    i_valid    = 1'b0;
    i_rs1_data = '0;
    i_rs2_data = '0;
    i_br_type  = 3'd0;
    i_flush    = 1'b0;
    i_ready    = 1'b0;
`ifdef BRC_SERIAL_PRED_EN
    i_pred_taken = 1'b0;
`endif
    #1;
    chk("reset_ready", {31'd0, o_ready}, 32'd1);
    chk("reset_outs",  {28'd0, o_valid, o_pc_sel, o_equal, o_less}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Flush in IDLE blocks acceptance.
    i_valid = 1'b1;
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    chk("flush_idle_ready", {31'd0, o_ready}, 32'd1);
    @(negedge i_clk);

    //    A             B             type  pred pc eq lt mis hold
    run(32'h1234_5678, 32'h1234_5678, 3'd0, 1'b1, 1, 1, 0, 0, 0);
    run(32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 1'b1, 1, 0, 1, 0, 1);
    run(32'hFFFF_FFFF, 32'h0000_0001, 3'd4, 1'b0, 0, 0, 0, 0, 0);
    run(32'h0000_0100, 32'h0000_00FF, 3'd5, 1'b1, 1, 0, 0, 0, 2);
    run(32'h0000_0005, 32'h0000_0007, 3'd1, 1'b1, 1, 0, 1, 0, 5);
    run(32'h0000_0000, 32'h0000_0000, 3'd6, 1'b0, 0, 1, 0, 0, 0);
    run(32'h8000_0000, 32'h7FFF_FFFF, 3'd3, 1'b0, 0, 0, 1, 0, 1);
    run(32'h0000_0000, 32'hFFFF_FFFF, 3'd4, 1'b1, 1, 0, 1, 0, 0);
    run(32'h0000_0100, 32'h0000_0000, 3'd0, 1'b0, 0, 0, 0, 0, 0);
    run(32'h0000_0005, 32'h0000_0007, 3'd3, 1'b1, 0, 0, 1, 1, 1);

    // Flush two cycles into BUSY: back to IDLE, no result.
    start_only(32'hAAAA_0000, 32'hAAAA_0000, 3'd0);
    @(posedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    chk("flush_busy_ready", {31'd0, o_ready}, 32'd1);
    chk("flush_busy_valid", {31'd0, o_valid}, 32'd0);
    repeat (NCHUNK + 3) @(negedge i_clk);

    // Reset pulse mid-BUSY: outputs clear immediately, accept right after.
    start_only(32'h0000_0001, 32'h0000_0002, 3'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_mid_outs",  {28'd0, o_valid, o_pc_sel, o_equal, o_less}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run(32'h0000_0009, 32'h0000_0003, 3'd5, 1'b0, 1, 0, 0, 1, 0);

    repeat (NCHUNK + 2) @(negedge i_clk);
    chk("queue_empty", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
